// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch front end.
package rv_fetch_pkg;

    // Instruction words are always 32 bits wide (no compressed instructions).
    localparam int INSTR_W = 32;

    // One 32-bit word spans two halfword address units.
    localparam int WORD_STEP = 2;

    // Source of the next program counter value.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_SEQ,
        PC_TARGET,
        PC_TRAP
    } pc_src_e;

endpackage

// File: rtl/rv_fetch_addr.sv
// Program counter, redirect/trap selection and in-flight request tracking.
module rv_fetch_addr
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
    parameter int          IADDR_SPACE_BITS = 16,
    parameter bit          EXTENSION_Zicsr  = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_pc_select,
    input  logic [IADDR_SPACE_BITS-1:1] i_pc_target,
    input  logic                        i_ebreak,
    input  logic [IADDR_SPACE_BITS-1:1] i_pc_trap,
    input  logic                        i_ack,
    input  logic                        i_cyc,
    output logic                        o_change,
    output logic [IADDR_SPACE_BITS-1:1] o_pc,
    output logic                        o_pending,
    output logic [IADDR_SPACE_BITS-1:1] o_pending_pc
);

    localparam logic [IADDR_SPACE_BITS-1:1] RESET_PC = RESET_ADDR[IADDR_SPACE_BITS-1:1];
    localparam logic [IADDR_SPACE_BITS-1:1] STEP     = (IADDR_SPACE_BITS-1)'(WORD_STEP);

    logic                        trap_req;
    logic                        change;
    logic                        accept;
    pc_src_e                     pc_src;
    logic [IADDR_SPACE_BITS-1:1] pc;
    logic [IADDR_SPACE_BITS-1:1] pc_next;
    logic                        pending;
    logic [IADDR_SPACE_BITS-1:1] pending_pc;

    // Decode redirect requests and pick where the PC comes from next.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch can be inferred.
        trap_req = 1'b0;
        change   = 1'b0;
        accept   = 1'b0;
        pc_src   = PC_HOLD;

        trap_req = EXTENSION_Zicsr && i_ebreak;
        change   = !i_reset && (i_pc_select || trap_req);
        // A bus ack in a redirect cycle belongs to the discarded stream.
        accept   = i_ack && i_cyc && !change;

        if (change && trap_req) begin
            pc_src = PC_TRAP;
        end else if (change) begin
            pc_src = PC_TARGET;
        end else if (i_ack && i_cyc) begin
            pc_src = PC_SEQ;
        end
    end

    // Next-PC mux; the sequential step wraps modulo the address width.
    always_comb begin
        pc_next = pc;
        unique case (pc_src)
            PC_SEQ:    pc_next = pc + STEP;
            PC_TARGET: pc_next = i_pc_target;
            PC_TRAP:   pc_next = i_pc_trap;
            default:   pc_next = pc;
        endcase
    end

    // PC register and the one-deep record of the request whose data returns next cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else begin
            pc      <= pc_next;
            pending <= accept;
            if (accept) begin
                pending_pc <= pc;
            end
        end
    end

    assign o_change     = change;
    assign o_pc         = pc;
    assign o_pending    = pending;
    assign o_pending_pc = pending_pc;

endmodule

// File: rtl/rv_fetch_buf.sv
// Instruction FIFO of {word, pc} pairs with head outputs and count-based flow control.
module rv_fetch_buf
    import rv_fetch_pkg::*;
#(
    parameter int IADDR_SPACE_BITS    = 16,
    parameter int INSTR_BUF_ADDR_SIZE = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_stall,
    input  logic                        i_pending,
    input  logic [IADDR_SPACE_BITS-1:1] i_push_pc,
    input  logic [INSTR_W-1:0]          i_push_data,
    output logic [INSTR_W-1:0]          o_instruction,
    output logic [IADDR_SPACE_BITS-1:1] o_pc,
    output logic [IADDR_SPACE_BITS-1:1] o_pc_next,
    output logic                        o_ready,
    output logic                        o_not_full
);

    localparam int DEPTH = 1 << INSTR_BUF_ADDR_SIZE;
    localparam int PW    = INSTR_BUF_ADDR_SIZE;
    localparam int CW    = INSTR_BUF_ADDR_SIZE + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW:0]   SUM_DEPTH = (CW+1)'(DEPTH);
    localparam logic [IADDR_SPACE_BITS-1:1] STEP = (IADDR_SPACE_BITS-1)'(WORD_STEP);

    logic [INSTR_W-1:0]          data_mem [DEPTH];
    logic [IADDR_SPACE_BITS-1:1] pc_mem   [DEPTH];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic                        full;
    logic                        push;
    logic                        pop;
    logic                        do_push;

    // Flow control: a slot is reserved for the word already in flight on the bus.
    always_comb begin
        full       = (count == CNT_DEPTH);
        o_ready    = (count != '0);
        pop        = o_ready && !i_stall;
        push       = i_pending && !i_flush;
        // Cannot happen while the request gate works; if it does, the word is dropped.
        do_push    = push && (!full || pop);
        o_not_full = ({1'b0, count} + (CW+1)'(i_pending)) < SUM_DEPTH;
    end

    // Head of queue as seen by the decoder.
    always_comb begin
        o_instruction = data_mem[rd_ptr];
        o_pc          = pc_mem[rd_ptr];
        o_pc_next     = pc_mem[rd_ptr] + STEP;
    end

    // Pointers and occupancy; a redirect empties the queue synchronously.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({do_push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array is not reset; entry validity is tracked by count alone.
        if (do_push) begin
            data_mem[wr_ptr] <= i_push_data;
            pc_mem[wr_ptr]   <= i_push_pc;
        end
    end

endmodule

// File: rtl/rv_fetch_frontend.sv
// RV32 instruction-fetch front end: bus requests, PC tracking and the decode-side queue.
module rv_fetch_frontend
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR          = 32'h0000_0000,
    parameter int          IADDR_SPACE_BITS    = 16,
    parameter int          INSTR_BUF_ADDR_SIZE = 2,
    parameter bit          EXTENSION_Zicsr     = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_stall,
    input  logic [IADDR_SPACE_BITS-1:1] i_pc_target,
    input  logic                        i_pc_select,
    input  logic [IADDR_SPACE_BITS-1:1] i_pc_trap,
    input  logic                        i_ebreak,
    input  logic [INSTR_W-1:0]          i_instruction,
    input  logic                        i_ack,
    output logic                        o_pc_change,
    output logic [IADDR_SPACE_BITS-1:1] o_addr,
    output logic                        o_cyc,
    output logic [INSTR_W-1:0]          o_instruction,
    output logic [IADDR_SPACE_BITS-1:1] o_pc,
    output logic [IADDR_SPACE_BITS-1:1] o_pc_next,
    output logic                        o_ready
);

    logic                        change;
    logic                        pending;
    logic [IADDR_SPACE_BITS-1:1] pending_pc;
    logic [IADDR_SPACE_BITS-1:1] pc;
    logic                        not_full;

    rv_fetch_addr #(
        .RESET_ADDR       (RESET_ADDR),
        .IADDR_SPACE_BITS (IADDR_SPACE_BITS),
        .EXTENSION_Zicsr  (EXTENSION_Zicsr)
    ) u_addr (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pc_select  (i_pc_select),
        .i_pc_target  (i_pc_target),
        .i_ebreak     (i_ebreak),
        .i_pc_trap    (i_pc_trap),
        .i_ack        (i_ack),
        .i_cyc        (o_cyc),
        .o_change     (change),
        .o_pc         (pc),
        .o_pending    (pending),
        .o_pending_pc (pending_pc)
    );

    rv_fetch_buf #(
        .IADDR_SPACE_BITS    (IADDR_SPACE_BITS),
        .INSTR_BUF_ADDR_SIZE (INSTR_BUF_ADDR_SIZE)
    ) u_buf (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_flush       (change),
        .i_stall       (i_stall),
        .i_pending     (pending),
        .i_push_pc     (pending_pc),
        .i_push_data   (i_instruction),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_pc_next     (o_pc_next),
        .o_ready       (o_ready),
        .o_not_full    (not_full)
    );

    // Requests are only issued when every in-flight word is guaranteed a slot.
    assign o_cyc       = not_full && !i_reset;
    assign o_addr      = pc;
    assign o_pc_change = change;

endmodule

// File: tb/tb_rv_fetch_frontend.sv
// Directed bench for rv_fetch_frontend: table-driven streaming/stall vectors plus
// hand-written redirect, trap, wrap and mid-stream reset sequences.
module tb_rv_fetch_frontend;

    localparam int          IAB   = 16;
    localparam logic [31:0] RST_A = 32'h0000_0100;

    typedef logic [IAB-1:1] addr_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_stall;
    addr_t       i_pc_target;
    logic        i_pc_select;
    addr_t       i_pc_trap;
    logic        i_ebreak;
    logic [31:0] i_instruction;
    logic        i_ack;

    logic        o_pc_change, o_cyc, o_ready;
    addr_t       o_addr, o_pc, o_pc_next;
    logic [31:0] o_instruction;

    logic        nz_pc_change, nz_cyc, nz_ready;
    addr_t       nz_addr, nz_pc, nz_pc_next;
    logic [31:0] nz_instruction;

    int checks = 0;
    int errors = 0;

    rv_fetch_frontend #(
        .RESET_ADDR          (RST_A),
        .IADDR_SPACE_BITS    (IAB),
        .INSTR_BUF_ADDR_SIZE (2),
        .EXTENSION_Zicsr     (1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_stall       (i_stall),
        .i_pc_target   (i_pc_target),
        .i_pc_select   (i_pc_select),
        .i_pc_trap     (i_pc_trap),
        .i_ebreak      (i_ebreak),
        .i_instruction (i_instruction),
        .i_ack         (i_ack),
        .o_pc_change   (o_pc_change),
        .o_addr        (o_addr),
        .o_cyc         (o_cyc),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_pc_next     (o_pc_next),
        .o_ready       (o_ready)
    );

    // Same stimulus, trap support disabled.
    rv_fetch_frontend #(
        .RESET_ADDR          (RST_A),
        .IADDR_SPACE_BITS    (IAB),
        .INSTR_BUF_ADDR_SIZE (2),
        .EXTENSION_Zicsr     (1'b0)
    ) dut_nz (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_stall       (i_stall),
        .i_pc_target   (i_pc_target),
        .i_pc_select   (i_pc_select),
        .i_pc_trap     (i_pc_trap),
        .i_ebreak      (i_ebreak),
        .i_instruction (i_instruction),
        .i_ack         (i_ack),
        .o_pc_change   (nz_pc_change),
        .o_addr        (nz_addr),
        .o_cyc         (nz_cyc),
        .o_instruction (nz_instruction),
        .o_pc          (nz_pc),
        .o_pc_next     (nz_pc_next),
        .o_ready       (nz_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        stall;
        logic        ack;
        logic [31:0] instr;
        logic        exp_cyc;
        addr_t       exp_addr;
        logic        exp_ready;
        addr_t       exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic stall, input logic ack, input logic [31:0] instr,
                       input logic exp_cyc, input addr_t exp_addr, input logic exp_ready,
                       input addr_t exp_pc, input logic [31:0] exp_instr);
        vec_t v;
        v.stall     = stall;
        v.ack       = ack;
        v.instr     = instr;
        v.exp_cyc   = exp_cyc;
        v.exp_addr  = exp_addr;
        v.exp_ready = exp_ready;
        v.exp_pc    = exp_pc;
        v.exp_instr = exp_instr;
        vecs.push_back(v);
    endtask

    // Apply one cycle of inputs and let combinational outputs settle.
    task automatic drive(input logic stall, input logic sel, input addr_t target,
                         input logic ebreak, input addr_t trap, input logic ack,
                         input logic [31:0] instr);
        i_stall       = stall;
        i_pc_select   = sel;
        i_pc_target   = target;
        i_ebreak      = ebreak;
        i_pc_trap     = trap;
        i_ack         = ack;
        i_instruction = instr;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Streaming: ack every cycle, data A0..A3 arrives one cycle after each ack.
        //    stall ack  instr        cyc  addr      rdy  head pc   head word
        add(1'b0, 1'b1, 32'h0,     1'b1, 15'h080, 1'b0, 15'h000, 32'h0);
        add(1'b0, 1'b1, 32'hA0,    1'b1, 15'h082, 1'b0, 15'h000, 32'h0);
        add(1'b0, 1'b1, 32'hA1,    1'b1, 15'h084, 1'b1, 15'h080, 32'hA0);
        add(1'b0, 1'b1, 32'hA2,    1'b1, 15'h086, 1'b1, 15'h082, 32'hA1);
        add(1'b0, 1'b0, 32'hA3,    1'b1, 15'h088, 1'b1, 15'h084, 32'hA2);
        add(1'b0, 1'b0, 32'h0,     1'b1, 15'h088, 1'b1, 15'h086, 32'hA3);
        add(1'b0, 1'b0, 32'h0,     1'b1, 15'h088, 1'b0, 15'h000, 32'h0);
        // Stalled decoder with ack held high: exactly four words are accepted.
        add(1'b1, 1'b1, 32'h0,     1'b1, 15'h088, 1'b0, 15'h000, 32'h0);
        add(1'b1, 1'b1, 32'hB0,    1'b1, 15'h08A, 1'b0, 15'h000, 32'h0);
        add(1'b1, 1'b1, 32'hB1,    1'b1, 15'h08C, 1'b1, 15'h088, 32'hB0);
        add(1'b1, 1'b1, 32'hB2,    1'b1, 15'h08E, 1'b1, 15'h088, 32'hB0);
        add(1'b1, 1'b1, 32'hB3,    1'b0, 15'h090, 1'b1, 15'h088, 32'hB0);
        add(1'b1, 1'b1, 32'h0,     1'b0, 15'h090, 1'b1, 15'h088, 32'hB0);
        // Release stall for one pop; requests resume the following cycle.
        add(1'b0, 1'b1, 32'h0,     1'b0, 15'h090, 1'b1, 15'h088, 32'hB0);
        add(1'b1, 1'b1, 32'h0,     1'b1, 15'h090, 1'b1, 15'h08A, 32'hB1);

        // Reset state (a redirect request during reset must not show as a change).
        i_reset = 1'b1;
        drive(1'b0, 1'b1, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        next_cycle();
        check("reset_cyc", 32'(o_cyc), 32'h0);
        check("reset_ready", 32'(o_ready), 32'h0);
        check("reset_change", 32'(o_pc_change), 32'h0);
        check("reset_addr", 32'(o_addr), 32'h080);
        i_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            addr_t nxt;
            drive(vecs[i].stall, 1'b0, 15'h000, 1'b0, 15'h000, vecs[i].ack, vecs[i].instr);
            check($sformatf("row%0d_cyc", i), 32'(o_cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("row%0d_addr", i), 32'(o_addr), 32'(vecs[i].exp_addr));
            check($sformatf("row%0d_ready", i), 32'(o_ready), 32'(vecs[i].exp_ready));
            check($sformatf("row%0d_change", i), 32'(o_pc_change), 32'h0);
            if (vecs[i].exp_ready) begin
                nxt = vecs[i].exp_pc + 15'd2;
                check($sformatf("row%0d_pc", i), 32'(o_pc), 32'(vecs[i].exp_pc));
                check($sformatf("row%0d_word", i), o_instruction, vecs[i].exp_instr);
                check($sformatf("row%0d_pc_next", i), 32'(o_pc_next), 32'(nxt));
            end
            next_cycle();
        end

        // Redirect with 3 words queued and an ack in flight (its data is discarded).
        drive(1'b1, 1'b1, 15'h200, 1'b0, 15'h000, 1'b1, 32'hC0);
        check("redir_change", 32'(o_pc_change), 32'h1);
        check("redir_ready_before", 32'(o_ready), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b1, 32'h0);
        check("redir_change_clear", 32'(o_pc_change), 32'h0);
        check("redir_ready_flushed", 32'(o_ready), 32'h0);
        check("redir_addr", 32'(o_addr), 32'h200);
        check("redir_cyc", 32'(o_cyc), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'hD0);
        check("redir_ready_lat", 32'(o_ready), 32'h0);
        check("redir_addr_seq", 32'(o_addr), 32'h202);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("redir_head_ready", 32'(o_ready), 32'h1);
        check("redir_head_pc", 32'(o_pc), 32'h200);
        check("redir_head_word", o_instruction, 32'hD0);
        check("redir_head_pc_next", 32'(o_pc_next), 32'h202);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("redir_drained", 32'(o_ready), 32'h0);

        // Trap and redirect together: trap wins only when the extension is present.
        drive(1'b0, 1'b1, 15'h300, 1'b1, 15'h010, 1'b0, 32'h0);
        check("trap_change", 32'(o_pc_change), 32'h1);
        check("trap_nz_change", 32'(nz_pc_change), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("trap_addr", 32'(o_addr), 32'h010);
        check("trap_nz_addr", 32'(nz_addr), 32'h300);
        drive(1'b0, 1'b0, 15'h300, 1'b1, 15'h010, 1'b0, 32'h0);
        check("ebreak_only_change", 32'(o_pc_change), 32'h1);
        check("ebreak_only_nz_change", 32'(nz_pc_change), 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("ebreak_only_addr", 32'(o_addr), 32'h010);
        check("ebreak_only_nz_addr", 32'(nz_addr), 32'h300);

        // PC wrap at the top of the address space.
        drive(1'b0, 1'b1, 15'h7FFE, 1'b0, 15'h000, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b1, 32'h0);
        check("wrap_addr_top", 32'(o_addr), 32'h7FFE);
        check("wrap_cyc", 32'(o_cyc), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'hE0);
        check("wrap_addr_zero", 32'(o_addr), 32'h0000);
        next_cycle();
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("wrap_head_pc", 32'(o_pc), 32'h7FFE);
        check("wrap_head_pc_next", 32'(o_pc_next), 32'h0000);
        check("wrap_head_word", o_instruction, 32'hE0);
        next_cycle();

        // Reset asserted mid-stream with words queued.
        drive(1'b1, 1'b0, 15'h000, 1'b0, 15'h000, 1'b1, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 15'h000, 1'b0, 15'h000, 1'b1, 32'hF0);
        next_cycle();
        drive(1'b1, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'hF1);
        next_cycle();
        drive(1'b1, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("mid_ready_pre", 32'(o_ready), 32'h1);
        check("mid_addr_pre", 32'(o_addr), 32'h004);
        check("mid_word_pre", o_instruction, 32'hF0);
        i_reset = 1'b1;
        #1;
        check("mid_reset_ready", 32'(o_ready), 32'h0);
        check("mid_reset_cyc", 32'(o_cyc), 32'h0);
        check("mid_reset_addr", 32'(o_addr), 32'h080);
        next_cycle();
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 15'h000, 1'b0, 15'h000, 1'b0, 32'h0);
        check("post_reset_cyc", 32'(o_cyc), 32'h1);
        check("post_reset_addr", 32'(o_addr), 32'h080);
        check("post_reset_ready", 32'(o_ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
